// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
//
// Execute stage of a five-stage MIPS-style pipeline, together with the EX/MEM
// pipeline register. Single-cycle ALU operations issue a result on the edge
// that accepts them. A multiply runs on a 32-iteration shift-add engine and
// holds the stage busy until its product is written into EX/MEM.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid          ID/EX fields carry a real instruction
//   WB, M             write-back / memory control, passed through
//   RegDst            write register select (1 = RD, 0 = RT)
//   ALUop, ALUsrc     ALU operation class, operand-B select (1 = SignExt)
//   NextAdress        PC+4 of the instruction
//   OP1, OP2          register operands
//   SignExt           sign-extended immediate, bits [5:0] hold funct
//   RT, RD            register specifiers
//   mem_stall         downstream hold, EX/MEM register freezes
//   flush             synchronous squash of the stage
//   busy              stage cannot accept (multiply in progress)
//   out_valid         EX/MEM holds a real instruction
//   O_*               registered EX/MEM fields
// ----------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic        RegDst,
    input  logic [1:0]  ALUop,
    input  logic        ALUsrc,
    input  logic [31:0] NextAdress,
    input  logic [31:0] OP1,
    input  logic [31:0] OP2,
    input  logic [31:0] SignExt,
    input  logic [4:0]  RT,
    input  logic [4:0]  RD,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        busy,
    output logic        out_valid,
    output logic [1:0]  O_WB,
    output logic [2:0]  O_M,
    output logic [31:0] O_ALUResult,
    output logic        O_Zero,
    output logic [31:0] O_BranchTarget,
    output logic [31:0] O_WriteData,
    output logic [4:0]  O_WriteReg
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_count;

    // Shift-add engine: only the low 32 product bits are ever needed, so the
    // accumulator and the left-shifting multiplicand are both 32 bits wide.
    logic [31:0] r_mulAcc;
    logic [31:0] r_multiplicand;
    logic [31:0] r_multiplier;

    // Fields of the multiply captured at issue, released with the product.
    logic [1:0]  r_mulWB;
    logic [2:0]  r_mulM;
    logic [4:0]  r_mulWriteReg;
    logic [31:0] r_mulBranchTarget;
    logic [31:0] r_mulWriteData;

    // EX/MEM register.
    logic        r_outValid;
    logic [1:0]  r_oWB;
    logic [2:0]  r_oM;
    logic [31:0] r_oALUResult;
    logic        r_oZero;
    logic [31:0] r_oBranchTarget;
    logic [31:0] r_oWriteData;
    logic [4:0]  r_oWriteReg;

    logic [31:0] w_opB;
    logic [5:0]  w_funct;
    logic [31:0] w_aluResult;
    logic        w_isMult;
    logic [31:0] w_branchTarget;
    logic [4:0]  w_writeReg;
    logic        w_accept;
    logic [31:0] w_mulAdd;

    assign w_opB          = ALUsrc ? SignExt : OP2;
    assign w_funct        = SignExt[5:0];
    assign w_branchTarget = NextAdress + {SignExt[29:0], 2'b00};
    assign w_writeReg     = RegDst ? RD : RT;
    assign w_accept       = in_valid && (r_state == ST_IDLE) && !mem_stall && !flush;
    assign w_mulAdd       = r_mulAcc + (r_multiplier[0] ? r_multiplicand : 32'd0);

    // ALU decode. Unknown funct codes fall back to add so the stage never
    // produces an undefined value; mult is flagged and handled by the FSM.
    always_comb begin
        w_aluResult = OP1 + w_opB;
        w_isMult    = 1'b0;
        case (ALUop)
            2'b00: w_aluResult = OP1 + w_opB;
            2'b01: w_aluResult = OP1 - w_opB;
            2'b11: w_aluResult = OP1 | w_opB;
            default: begin
                case (w_funct)
                    6'h20: w_aluResult = OP1 + w_opB;
                    6'h22: w_aluResult = OP1 - w_opB;
                    6'h24: w_aluResult = OP1 & w_opB;
                    6'h25: w_aluResult = OP1 | w_opB;
                    6'h2A: w_aluResult = {31'd0, ($signed(OP1) < $signed(w_opB))};
                    6'h18: w_isMult    = 1'b1;
                    default: w_aluResult = OP1 + w_opB;
                endcase
            end
        endcase
    end

    // Pipeline register and multiplier FSM. Flush wins over everything. A
    // downstream stall freezes the EX/MEM register and the FSM, except that a
    // multiply in progress keeps iterating so the stall does not lengthen it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_count           <= 6'd0;
            r_mulAcc          <= 32'd0;
            r_multiplicand    <= 32'd0;
            r_multiplier      <= 32'd0;
            r_mulWB           <= 2'd0;
            r_mulM            <= 3'd0;
            r_mulWriteReg     <= 5'd0;
            r_mulBranchTarget <= 32'd0;
            r_mulWriteData    <= 32'd0;
            r_outValid        <= 1'b0;
            r_oWB             <= 2'd0;
            r_oM              <= 3'd0;
            r_oALUResult      <= 32'd0;
            r_oZero           <= 1'b0;
            r_oBranchTarget   <= 32'd0;
            r_oWriteData      <= 32'd0;
            r_oWriteReg       <= 5'd0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_count    <= 6'd0;
            r_outValid <= 1'b0;
            r_oWB      <= 2'd0;
            r_oM       <= 3'd0;
        end else begin
            if (r_state == ST_MUL) begin
                r_mulAcc       <= w_mulAdd;
                r_multiplicand <= {r_multiplicand[30:0], 1'b0};
                r_multiplier   <= {1'b0, r_multiplier[31:1]};
                r_count        <= r_count + 6'd1;
                if (r_count == 6'd31) begin
                    r_state <= ST_DONE;
                end
            end

            if (!mem_stall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && !w_isMult) begin
                            r_outValid      <= 1'b1;
                            r_oWB           <= WB;
                            r_oM            <= M;
                            r_oALUResult    <= w_aluResult;
                            r_oZero         <= (w_aluResult == 32'd0);
                            r_oBranchTarget <= w_branchTarget;
                            r_oWriteData    <= OP2;
                            r_oWriteReg     <= w_writeReg;
                        end else begin
                            r_outValid <= 1'b0;
                            r_oWB      <= 2'd0;
                            r_oM       <= 3'd0;
                        end
                        if (w_accept && w_isMult) begin
                            r_state           <= ST_MUL;
                            r_count           <= 6'd0;
                            r_mulAcc          <= 32'd0;
                            r_multiplicand    <= OP1;
                            r_multiplier      <= w_opB;
                            r_mulWB           <= WB;
                            r_mulM            <= M;
                            r_mulWriteReg     <= w_writeReg;
                            r_mulBranchTarget <= w_branchTarget;
                            r_mulWriteData    <= OP2;
                        end
                    end
                    ST_MUL: begin
                        r_outValid <= 1'b0;
                        r_oWB      <= 2'd0;
                        r_oM       <= 3'd0;
                    end
                    ST_DONE: begin
                        r_state         <= ST_IDLE;
                        r_outValid      <= 1'b1;
                        r_oWB           <= r_mulWB;
                        r_oM            <= r_mulM;
                        r_oALUResult    <= r_mulAcc;
                        r_oZero         <= (r_mulAcc == 32'd0);
                        r_oBranchTarget <= r_mulBranchTarget;
                        r_oWriteData    <= r_mulWriteData;
                        r_oWriteReg     <= r_mulWriteReg;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign out_valid      = r_outValid;
    assign O_WB           = r_oWB;
    assign O_M            = r_oM;
    assign O_ALUResult    = r_oALUResult;
    assign O_Zero         = r_oZero;
    assign O_BranchTarget = r_oBranchTarget;
    assign O_WriteData    = r_oWriteData;
    assign O_WriteReg     = r_oWriteReg;

endmodule
